// File: rtl/aes_stream_pkg.sv
// Shared types and helpers for the 32-bit to 128-bit AES block packing path.
package aes_stream_pkg;

  localparam int AES_BLK_W     = 128;
  localparam int AXIS_IN_W     = 32;
  localparam int WORDS_PER_BLK = 4;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
  } aes_blk_t;

  // A full word is always legal; a contiguous MSB-first partial word only closes a frame.
  function automatic logic keep_legal(input logic [3:0] keep, input logic last);
    logic legal;
    case (keep)
      4'b1111:                            legal = 1'b1;
      4'b1110, 4'b1100, 4'b1000, 4'b0000: legal = last;
      default:                            legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic [31:0] mask_word(input logic [31:0] data, input logic [3:0] keep);
    logic [31:0] masked;
    for (int j = 0; j < 4; j++) begin
      masked[8*j +: 8] = data[8*j +: 8] & {8{keep[j]}};
    end
    return masked;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// One-entry registered stream stage; output payload holds steady while stalled.
module axis_reg_slice
  import aes_stream_pkg::*;
#(
  parameter type T = aes_blk_t
) (
  input  logic clk,
  input  logic rst_n,
  input  T     in_data,
  input  logic in_valid,
  output logic in_ready,
  output T     out_data,
  output logic out_valid,
  input  logic out_ready
);

  assign in_ready = !out_valid || out_ready;

  // Entry register: reload whenever the current entry leaves (or is absent).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: rtl/axis_aes_block_packer.sv
// Packs a 32-bit AXI-Stream into zero-padded 128-bit AES blocks with byte masks,
// keeping frame ends aligned to block ends; also counts blocks and flags bad tkeep.
module axis_aes_block_packer
  import aes_stream_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [AXIS_IN_W-1:0] s_axis_tdata,
  input  logic [3:0]           s_axis_tkeep,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  output logic                 s_axis_tready,
  output logic [AES_BLK_W-1:0] m_axis_tdata,
  output logic [15:0]          m_axis_tkeep,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  output logic [CNT_W-1:0]     blk_count,
  output logic                 err_sticky
);

  logic [AES_BLK_W-1:0] acc_data, acc_data_nx;
  logic [15:0]          acc_keep, acc_keep_nx;
  logic                 acc_last, acc_last_nx;
  logic                 acc_full, acc_full_nx;
  logic [1:0]           idx, idx_nx;
  logic                 tready_r;

  logic [AXIS_IN_W-1:0] word_m;
  logic [6:0]           lane_sh;
  logic [AES_BLK_W-1:0] lane_data;
  logic [15:0]          lane_keep;
  logic                 accept, complete, bad_keep;
  aes_blk_t             merged, slot_in, slot_out;
  logic                 slot_valid, slot_ready;

  assign s_axis_tready = tready_r;

  // Merge the incoming word into its lane and decide where the accumulator goes next.
  always_comb begin
    word_m      = mask_word(s_axis_tdata, s_axis_tkeep);
    lane_sh     = {~idx, 5'd0};
    lane_data   = {{(AES_BLK_W-AXIS_IN_W){1'b0}}, word_m} << lane_sh;
    lane_keep   = {12'd0, s_axis_tkeep} << {~idx, 2'd0};
    accept      = s_axis_tvalid && tready_r;
    complete    = accept && ((idx == 2'(WORDS_PER_BLK - 1)) || s_axis_tlast);
    bad_keep    = accept && !keep_legal(s_axis_tkeep, s_axis_tlast);
    merged.data = acc_data | lane_data;
    merged.keep = acc_keep | lane_keep;
    merged.last = s_axis_tlast;

    // A held block has priority for the slot; tready is low while one is held.
    if (acc_full) begin
      slot_in    = '{data: acc_data, keep: acc_keep, last: acc_last};
      slot_valid = 1'b1;
    end else begin
      slot_in    = merged;
      slot_valid = complete;
    end

    acc_data_nx = acc_data;
    acc_keep_nx = acc_keep;
    acc_last_nx = acc_last;
    acc_full_nx = acc_full;
    idx_nx      = idx;
    if (complete) begin
      idx_nx = 2'd0;
      if (slot_ready) begin
        acc_data_nx = '0;
        acc_keep_nx = 16'd0;
        acc_last_nx = 1'b0;
      end else begin
        acc_data_nx = merged.data;
        acc_keep_nx = merged.keep;
        acc_last_nx = s_axis_tlast;
        acc_full_nx = 1'b1;
      end
    end else if (accept) begin
      acc_data_nx = merged.data;
      acc_keep_nx = merged.keep;
      idx_nx      = idx + 2'd1;
    end else if (acc_full && slot_ready) begin
      acc_data_nx = '0;
      acc_keep_nx = 16'd0;
      acc_last_nx = 1'b0;
      acc_full_nx = 1'b0;
    end else begin
      acc_full_nx = acc_full;
    end
  end

  // Accumulator state; tready mirrors !acc_full but only after the first edge out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_data <= '0;
      acc_keep <= 16'd0;
      acc_last <= 1'b0;
      acc_full <= 1'b0;
      idx      <= 2'd0;
      tready_r <= 1'b0;
    end else begin
      acc_data <= acc_data_nx;
      acc_keep <= acc_keep_nx;
      acc_last <= acc_last_nx;
      acc_full <= acc_full_nx;
      idx      <= idx_nx;
      tready_r <= !acc_full_nx;
    end
  end

  // Status: clear takes precedence over a same-cycle handshake or bad beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_count  <= '0;
      err_sticky <= 1'b0;
    end else if (clear) begin
      blk_count  <= '0;
      err_sticky <= 1'b0;
    end else begin
      blk_count  <= (m_axis_tvalid && m_axis_tready) ? blk_count + CNT_W'(1) : blk_count;
      err_sticky <= err_sticky | bad_keep;
    end
  end

  axis_reg_slice #(.T(aes_blk_t)) u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (slot_in),
    .in_valid  (slot_valid),
    .in_ready  (slot_ready),
    .out_data  (slot_out),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready)
  );

  assign m_axis_tdata = slot_out.data;
  assign m_axis_tkeep = slot_out.keep;
  assign m_axis_tlast = slot_out.last;

endmodule

// File: tb/tb_axis_aes_block_packer.sv
// Scoreboard bench: a lane-based block model fed by an input monitor, checked by an output monitor.
module tb_axis_aes_block_packer;

  logic         clk = 1'b0;
  logic         rst_n, clear;
  logic [31:0]  s_data;
  logic [3:0]   s_keep;
  logic         s_valid, s_last, s_ready;
  logic [127:0] m_data;
  logic [15:0]  m_keep;
  logic         m_valid, m_last, m_ready;
  logic [31:0]  blk_count;
  logic         err_sticky;

  always #5 clk = ~clk;

  axis_aes_block_packer #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tvalid(s_valid),
    .s_axis_tlast(s_last), .s_axis_tready(s_ready),
    .m_axis_tdata(m_data), .m_axis_tkeep(m_keep), .m_axis_tvalid(m_valid),
    .m_axis_tlast(m_last), .m_axis_tready(m_ready),
    .blk_count(blk_count), .err_sticky(err_sticky)
  );

  typedef struct {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
  } blk_t;

  int          checks = 0;
  int          errors = 0;
  blk_t        exp_q[$];
  logic [31:0] cur_w[$];
  logic [3:0]  cur_k[$];
  logic [31:0] exp_cnt = 32'd0;
  logic        exp_err = 1'b0;
  logic        rnd_ready = 1'b0;
  logic        watch_ready = 1'b0;
  logic        saw_ready_low = 1'b0;
  logic        stall_prev = 1'b0;
  blk_t        stall_blk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic legal(input logic [3:0] k, input logic last);
    return (k == 4'hF) || (last && (k == 4'hE || k == 4'hC || k == 4'h8 || k == 4'h0));
  endfunction

  // Monitor: models accepted beats as byte positions in a block and checks every output.
  always @(negedge clk) begin
    blk_t nb;
    blk_t got;
    if (!rst_n) begin
      chk("rst_s_ready", {127'd0, s_ready}, 128'd0);
      chk("rst_m_valid", {127'd0, m_valid}, 128'd0);
      chk("rst_m_last", {127'd0, m_last}, 128'd0);
      chk("rst_m_data", m_data, 128'd0);
      chk("rst_m_keep", {112'd0, m_keep}, 128'd0);
      chk("rst_blk_count", {96'd0, blk_count}, 128'd0);
      chk("rst_err", {127'd0, err_sticky}, 128'd0);
      exp_q.delete(); cur_w.delete(); cur_k.delete();
      exp_cnt = 32'd0; exp_err = 1'b0; stall_prev = 1'b0;
    end else begin
      chk("blk_count", {96'd0, blk_count}, {96'd0, exp_cnt});
      chk("err_sticky", {127'd0, err_sticky}, {127'd0, exp_err});
      if (stall_prev && m_valid) begin
        chk("stall_data", m_data, stall_blk.d);
        chk("stall_keep", {112'd0, m_keep}, {112'd0, stall_blk.k});
        chk("stall_last", {127'd0, m_last}, {127'd0, stall_blk.l});
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_block: got %h with nothing expected", m_data);
        end else begin
          got = exp_q.pop_front();
          chk("blk_data", m_data, got.d);
          chk("blk_keep", {112'd0, m_keep}, {112'd0, got.k});
          chk("blk_last", {127'd0, m_last}, {127'd0, got.l});
        end
      end
      stall_prev  = m_valid && !m_ready;
      stall_blk.d = m_data; stall_blk.k = m_keep; stall_blk.l = m_last;
      if (watch_ready && !s_ready) saw_ready_low = 1'b1;
      if (s_valid && s_ready) begin
        if (!clear && !legal(s_keep, s_last)) exp_err = 1'b1;
        cur_w.push_back(s_data);
        cur_k.push_back(s_keep);
        if (cur_w.size() == 4 || s_last) begin
          nb.d = 128'd0; nb.k = 16'd0; nb.l = s_last;
          for (int w = 0; w < cur_w.size(); w++) begin
            for (int j = 0; j < 4; j++) begin
              if (cur_k[w][3-j]) begin
                nb.d[127 - 8*(4*w + j) -: 8] = cur_w[w][31 - 8*j -: 8];
                nb.k[15 - (4*w + j)] = 1'b1;
              end
            end
          end
          exp_q.push_back(nb);
          cur_w.delete(); cur_k.delete();
        end
      end
      if (clear) begin
        exp_cnt = 32'd0; exp_err = 1'b0;
      end else if (m_valid && m_ready) begin
        exp_cnt = exp_cnt + 32'd1;
      end
    end
  end

  // Random output backpressure when enabled.
  always @(posedge clk) begin
    #1;
    if (rnd_ready) m_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, output int waited);
    s_data = d; s_keep = k; s_last = l; s_valid = 1'b1; waited = 0;
    @(negedge clk);
    while (!s_ready && waited < 1000) begin
      waited++;
      @(negedge clk);
    end
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: tready stayed %b, required 1", s_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  logic [31:0] vec1 [4] = '{32'h6BC1BEE2, 32'h2E409F96, 32'hE93D7E11, 32'h7393172A};
  logic [31:0] vec2 [6] = '{32'hAABBCCDD, 32'h11223344, 32'h55667788,
                            32'h99AABBCC, 32'hDDEEFF00, 32'h12345678};

  initial begin
    int w, tot, r;
    logic [3:0] k;
    logic l;
    logic [3:0] last_keeps [5] = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
    rst_n = 1'b0; clear = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    s_data = 32'd0; s_keep = 4'd0; m_ready = 1'b1;
    idle(3);
    rst_n = 1'b1;
    @(negedge clk);
    chk("tready_before_edge", {127'd0, s_ready}, 128'd0);
    @(negedge clk);
    chk("tready_after_edge", {127'd0, s_ready}, 128'd1);
    @(posedge clk); #1;

    // 1) known block, one-clock latency, back-to-back acceptance
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      send(vec1[i], 4'hF, (i == 3), w);
      tot += w;
    end
    @(negedge clk);
    chk("t1_latency_valid", {127'd0, m_valid}, 128'd1);
    chk("t1_data", m_data, 128'h6BC1BEE22E409F96E93D7E117393172A);
    chk("t1_keep", {112'd0, m_keep}, {112'd0, 16'hFFFF});
    chk("t1_throughput_waits", tot, 0);
    idle(2);
    chk("t1_blk_count", {96'd0, blk_count}, 128'd1);

    // 2) short final block
    for (int i = 0; i < 6; i++) send(vec2[i], (i == 5) ? 4'hC : 4'hF, (i == 5), w);
    idle(3);

    // 3) backpressure across a block boundary
    pulse_clear();
    watch_ready = 1'b1; saw_ready_low = 1'b0;
    fork
      for (int i = 0; i < 12; i++) send($urandom, 4'hF, (i == 11), w);
      begin
        repeat (4) @(posedge clk);
        #1 m_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    idle(4);
    watch_ready = 1'b0;
    chk("t3_tready_dropped", {127'd0, saw_ready_low}, 128'd1);
    chk("t3_blk_count", {96'd0, blk_count}, 128'd3);

    // 4) empty frame marker, illegal keep, clear
    send(32'hDEADBEEF, 4'h0, 1'b1, w);
    send(32'hCAFEF00D, 4'hA, 1'b0, w);
    @(negedge clk);
    chk("t4_err_set", {127'd0, err_sticky}, 128'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send($urandom, 4'hF, (i == 2), w);
    idle(2);
    pulse_clear();
    @(negedge clk);
    chk("t4_err_cleared", {127'd0, err_sticky}, 128'd0);
    @(posedge clk); #1;

    // clear on the same edge as an output handshake
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) send($urandom, 4'hF, (i == 3), w);
    idle(2);
    clear = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    chk("clear_wins", {96'd0, blk_count}, 128'd0);
    @(posedge clk); #1;

    // 5) reset mid-frame discards the partial block
    send(32'h01020304, 4'hF, 1'b0, w);
    send(32'h05060708, 4'hF, 1'b0, w);
    rst_n = 1'b0;
    #1;
    chk("t5_async_tready", {127'd0, s_ready}, 128'd0);
    chk("t5_async_valid", {127'd0, m_valid}, 128'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    for (int i = 0; i < 4; i++) send(vec1[i], 4'hF, (i == 3), w);
    idle(3);
    chk("t5_blk_count", {96'd0, blk_count}, 128'd1);

    // 6) random traffic with random backpressure
    rnd_ready = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 2) == 0) idle(1);
      if (n % 2500 == 2499) pulse_clear();
      l = ($urandom_range(0, 5) == 0);
      r = $urandom_range(0, 39);
      if (r == 0)      k = 4'hA;
      else if (r == 1) k = 4'hC;
      else if (l)      k = last_keeps[$urandom_range(0, 4)];
      else             k = 4'hF;
      send($urandom, k, l, w);
    end
    rnd_ready = 1'b0;
    #1 m_ready = 1'b1;
    idle(6);

    // sustained throughput with both sides ready
    tot = 0;
    for (int i = 0; i < 64; i++) begin
      send($urandom, 4'hF, (i % 7 == 6), w);
      tot += w;
    end
    chk("t6_throughput_waits", tot, 0);
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) idle(1);
    idle(2);
    chk("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
